// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/command codes, response bytes and parser states for the snake command decoder
package snake_pkg;
  localparam logic [2:0] SUP    = 3'd1;
  localparam logic [2:0] SLEFT  = 3'd2;
  localparam logic [2:0] SDOWN  = 3'd3;
  localparam logic [2:0] SRIGHT = 3'd4;
  localparam logic [7:0] CMD_UP      = 8'h01;
  localparam logic [7:0] CMD_LEFT    = 8'h02;
  localparam logic [7:0] CMD_DOWN    = 8'h03;
  localparam logic [7:0] CMD_RIGHT   = 8'h04;
  localparam logic [7:0] CMD_MODE0   = 8'h10;
  localparam logic [7:0] CMD_MODE1   = 8'h11;
  localparam logic [7:0] CMD_MODE2   = 8'h12;
  localparam logic [7:0] CMD_MODE3   = 8'h13;
  localparam logic [7:0] CMD_PAUSE   = 8'h20;
  localparam logic [7:0] CMD_RESTART = 8'h30;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  typedef enum logic [1:0] {P_IDLE, P_GET_CMD, P_GET_CHK} pstate_t;
  function automatic logic [2:0] opposite(input logic [2:0] d);
    return d == SUP ? SDOWN : d == SDOWN ? SUP : d == SLEFT ? SRIGHT : d == SRIGHT ? SLEFT : d;
  endfunction
endpackage

// File: rtl/snake_frame_parser.sv
// snake_frame_parser: header/cmd/check frame FSM with idle timeout; strobes are combinational so the top can register with one-cycle latency
module snake_frame_parser
  import snake_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 5000000,
  parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       err
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  pstate_t state, state_nx;
  logic [TW-1:0] cnt;
  logic timeout;
  assign timeout = state != P_IDLE && !rx_valid && cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= P_IDLE;
      cmd   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx == P_IDLE || rx_valid) ? '0 : cnt + 1'b1;
      if (state == P_GET_CMD && rx_valid) cmd <= rx_data;
    end
  end
  always_comb begin
    state_nx  = state;
    cmd_valid = 1'b0;
    err       = 1'b0;
    case (state)
      P_IDLE:    state_nx = (rx_valid && rx_data == HDR_BYTE) ? P_GET_CMD : P_IDLE;
      P_GET_CMD: begin
        state_nx = rx_valid ? P_GET_CHK : timeout ? P_IDLE : P_GET_CMD;
        err      = timeout;
      end
      P_GET_CHK: begin
        state_nx  = (rx_valid || timeout) ? P_IDLE : P_GET_CHK;
        cmd_valid = rx_valid && rx_data == ~cmd;
        err       = (rx_valid && rx_data != ~cmd) || timeout;
      end
      default:   state_nx = P_IDLE;
    endcase
  end
endmodule

// File: rtl/snake_cmd_decoder.sv
// snake_cmd_decoder: turns framed UART commands into registered snake-core controls; SNAKE_CMD_ACK_EN adds an ACK/NAK response port
module snake_cmd_decoder
  import snake_pkg::*;
#(
  parameter int         CLK_HZ        = 50000000,
  parameter int         TIMEOUT_CYC   = CLK_HZ / 10,
  parameter int         RST_PULSE_CYC = 16,
  parameter logic [7:0] HDR_BYTE      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       move_tick,
  output logic [2:0] direction,
  output logic [1:0] mode,
  output logic       rst1,
  output logic       pause,
  output logic       frame_err
`ifdef SNAKE_CMD_ACK_EN
  ,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
`endif
);
  localparam int RW = $clog2(RST_PULSE_CYC + 1);
  logic [7:0] cmd;
  logic cmd_valid, err;
  logic [2:0] pending;
  logic [RW-1:0] rst_cnt;
  logic is_dir, restart, tick_ok, reject, accept, drop;
  snake_frame_parser #(.TIMEOUT_CYC(TIMEOUT_CYC), .HDR_BYTE(HDR_BYTE)) u_parser (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd(cmd), .cmd_valid(cmd_valid), .err(err)
  );
  assign is_dir  = cmd_valid && cmd inside {CMD_UP, CMD_LEFT, CMD_DOWN, CMD_RIGHT};
  assign restart = cmd_valid && cmd == CMD_RESTART;
  assign tick_ok = move_tick && rst1 && !pause;
  // reversal test uses the direction before any commit in this cycle
  assign reject  = is_dir && rst1 && cmd[2:0] == opposite(direction);
  assign accept  = is_dir && rst1 && !reject;
  // a pending turn that became a reversal after an intervening commit is dropped
  assign drop    = tick_ok && pending == opposite(direction);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      direction <= SRIGHT;
      pending   <= SRIGHT;
      mode      <= 2'd0;
      rst1      <= 1'b1;
      pause     <= 1'b0;
      frame_err <= 1'b0;
      rst_cnt   <= '0;
    end else begin
      frame_err <= err;
      if (cmd_valid && cmd inside {CMD_MODE0, CMD_MODE1, CMD_MODE2, CMD_MODE3}) mode <= cmd[1:0];
      if (restart) begin
        rst1      <= 1'b0;
        rst_cnt   <= RW'(RST_PULSE_CYC - 1);
        direction <= SRIGHT;
        pending   <= SRIGHT;
        pause     <= 1'b0;
      end else begin
        if (!rst1) begin
          if (rst_cnt == '0) rst1 <= 1'b1;
          else rst_cnt <= rst_cnt - 1'b1;
        end
        if (cmd_valid && cmd == CMD_PAUSE) pause <= !pause;
        if (tick_ok && !drop) direction <= pending;
        pending <= accept ? cmd[2:0] : drop ? direction : pending;
      end
    end
  end
`ifdef SNAKE_CMD_ACK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (cmd_valid || err) begin
      tx_data  <= (err || reject) ? NAK_BYTE : ACK_BYTE;
      tx_valid <= 1'b1;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_snake_cmd_decoder.sv
// tb_snake_cmd_decoder: table-driven frame vectors through a scoreboard queue plus hand-written restart/timeout/reset sequences
module tb_snake_cmd_decoder;
  localparam int TO = 40;
  localparam int RP = 16;
  logic clk = 1'b0, rst = 1'b0, rx_valid = 1'b0, move_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [2:0] direction;
  logic [1:0] mode;
  logic rst1, pause, frame_err;
  int total = 0, bad = 0;
`ifdef SNAKE_CMD_ACK_EN
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b1;
`endif
  snake_cmd_decoder #(.TIMEOUT_CYC(TO), .RST_PULSE_CYC(RP)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .move_tick(move_tick),
    .direction(direction), .mode(mode), .rst1(rst1), .pause(pause), .frame_err(frame_err)
`ifdef SNAKE_CMD_ACK_EN
    , .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] chk;
    logic       tick;
    logic [2:0] dir;
    logic [1:0] mode;
    logic       pause;
    logic       err;
  } vec_t;
  localparam int NV = 15;
  vec_t vecs[NV];
  vec_t sb[$];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic t);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    move_tick = t;
    @(negedge clk);
    rx_valid = 1'b0;
    move_tick = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] c, input logic [7:0] k, input logic t);
    send_byte(8'hA5, 1'b0);
    send_byte(c, 1'b0);
    send_byte(k, t);
  endtask
  task automatic tick();
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask
  task automatic count_low(output int n);
    n = 0;
    while (!rst1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t e;
    logic got_err, saw_err;
    int n, k;
    vecs[0]  = '{8'h01, 8'hFE, 1'b1, 3'd1, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'hFC, 1'b1, 3'd1, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{8'h02, 8'hFD, 1'b1, 3'd2, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{8'h04, 8'hFB, 1'b1, 3'd2, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{8'h11, 8'hEE, 1'b0, 3'd2, 2'd1, 1'b0, 1'b0};
    vecs[5]  = '{8'h11, 8'h00, 1'b0, 3'd2, 2'd1, 1'b0, 1'b1};
    vecs[6]  = '{8'h13, 8'hEC, 1'b0, 3'd2, 2'd3, 1'b0, 1'b0};
    vecs[7]  = '{8'h55, 8'hAA, 1'b0, 3'd2, 2'd3, 1'b0, 1'b0};
    vecs[8]  = '{8'h03, 8'hFC, 1'b1, 3'd3, 2'd3, 1'b0, 1'b0};
    vecs[9]  = '{8'h20, 8'hDF, 1'b0, 3'd3, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{8'h04, 8'hFB, 1'b1, 3'd3, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{8'h20, 8'hDF, 1'b1, 3'd4, 2'd3, 1'b0, 1'b0};
    vecs[12] = '{8'h12, 8'hED, 1'b0, 3'd4, 2'd2, 1'b0, 1'b0};
    vecs[13] = '{8'hA5, 8'h5A, 1'b0, 3'd4, 2'd2, 1'b0, 1'b0};
    vecs[14] = '{8'h02, 8'hFD, 1'b1, 3'd4, 2'd2, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset direction", direction, 4);
    chk("reset mode", mode, 0);
    chk("reset rst1", rst1, 1);
    chk("reset pause", pause, 0);
    chk("reset frame_err", frame_err, 0);
    for (int i = 0; i < NV; i++) begin
      sb.push_back(vecs[i]);
      send_frame(vecs[i].cmd, vecs[i].chk, 1'b0);
      got_err = frame_err;
      if (vecs[i].tick) tick();
      e = sb.pop_front();
      chk($sformatf("vec%0d frame_err", i), got_err, e.err);
      chk($sformatf("vec%0d direction", i), direction, e.dir);
      chk($sformatf("vec%0d mode", i), mode, e.mode);
      chk($sformatf("vec%0d pause", i), pause, e.pause);
    end
    send_frame(8'h01, 8'hFE, 1'b0);
    send_frame(8'h03, 8'hFC, 1'b0);
    tick();
    chk("last request wins", direction, 3);
    send_frame(8'h20, 8'hDF, 1'b0);
    chk("pause before restart", pause, 1);
    send_frame(8'h30, 8'hCF, 1'b0);
    chk("restart rst1 low", rst1, 0);
    chk("restart direction", direction, 4);
    chk("restart pause", pause, 0);
    chk("restart mode kept", mode, 2);
    fork
      count_low(n);
      begin
        repeat (2) @(negedge clk);
        tick();
        send_frame(8'h01, 8'hFE, 1'b0);
        tick();
      end
    join
    chk("restart pulse length", n, RP);
    chk("direction after pulse", direction, 4);
    tick();
    chk("discarded turn in pulse", direction, 4);
    send_frame(8'h30, 8'hCF, 1'b0);
    repeat (5) @(negedge clk);
    send_frame(8'h30, 8'hCF, 1'b0);
    count_low(n);
    chk("retriggered pulse length", n, RP);
    send_frame(8'h01, 8'hFE, 1'b1);
    chk("same-cycle commit uses old pending", direction, 4);
    tick();
    chk("same-cycle new pending commits", direction, 1);
    send_frame(8'h02, 8'hFD, 1'b0);
    send_frame(8'h04, 8'hFB, 1'b1);
    chk("same-cycle commit to left", direction, 2);
    tick();
    chk("stale reversal dropped", direction, 2);
    tick();
    chk("direction stable after drop", direction, 2);
    send_byte(8'hA5, 1'b0);
    k = 0;
    while (!frame_err && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("timeout cycles", k, TO);
    send_frame(8'h13, 8'hEC, 1'b0);
    chk("frame after timeout err", frame_err, 0);
    chk("frame after timeout mode", mode, 3);
    saw_err = 1'b0;
    send_byte(8'hA5, 1'b0);
    repeat (30) begin @(negedge clk); saw_err |= frame_err; end
    send_byte(8'h10, 1'b0);
    repeat (30) begin @(negedge clk); saw_err |= frame_err; end
    send_byte(8'hEF, 1'b0);
    saw_err |= frame_err;
    chk("byte clears timeout", saw_err, 0);
    chk("slow frame mode", mode, 0);
    send_frame(8'h13, 8'hEC, 1'b0);
    send_frame(8'h20, 8'hDF, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async reset direction", direction, 4);
    chk("async reset mode", mode, 0);
    chk("async reset pause", pause, 0);
    chk("async reset rst1", rst1, 1);
    @(negedge clk);
    rst = 1'b1;
    send_byte(8'hEE, 1'b0);
    chk("parser idle after reset err", frame_err, 0);
    chk("parser idle after reset mode", mode, 0);
    send_frame(8'h12, 8'hED, 1'b0);
    chk("frame after reset", mode, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
